// File: rtl/elevator_request_scheduler.sv
// SCAN call scheduler: latches floor calls, dispatches targets to the car FSM, times door dwell.
// Optional en-route pickup (retarget to a closer call ahead) when SCHED_ENROUTE_EN is defined.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS   = 10,
    parameter int DWELL_CYCLES = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NUM_FLOORS-1:0] i_call_req,
    input  logic [3:0]            i_current_floor,
    input  logic                  i_car_idle,
    output logic [3:0]            o_target_floor,
    output logic                  o_target_valid,
    output logic                  o_dir_up,
    output logic                  o_door_open,
    output logic [NUM_FLOORS-1:0] o_pending
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAVEL,
        ST_DWELL
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] w_pending_nxt;
    logic [3:0]            r_target;
    logic [3:0]            w_target_nxt;
    logic                  r_dir_up;
    logic                  w_dir_up_nxt;
    logic [CNT_W-1:0]      r_dwell_cnt;
    logic [CNT_W-1:0]      w_dwell_cnt_nxt;

    logic [NUM_FLOORS-1:0] w_cur_onehot;
    logic [NUM_FLOORS-1:0] w_tgt_onehot;
    logic [NUM_FLOORS-1:0] w_clear;
    logic [NUM_FLOORS-1:0] w_absorb;
    logic                  w_above_found;
    logic [3:0]            w_above_floor;
    logic                  w_below_found;
    logic [3:0]            w_below_floor;

    // An out-of-range current floor decodes to an all-zero one-hot, so it never matches a call.
    always_comb begin
        w_cur_onehot = '0;
        w_tgt_onehot = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            w_cur_onehot[f] = ({1'b0, i_current_floor} == 5'(f));
            w_tgt_onehot[f] = ({1'b0, r_target} == 5'(f));
        end
    end

    always_comb begin
        w_above_found = 1'b0;
        w_above_floor = '0;
        w_below_found = 1'b0;
        w_below_floor = '0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (r_pending[f] && (5'(f) > {1'b0, i_current_floor})) begin
                w_above_found = 1'b1;
                w_above_floor = 4'(f);
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (r_pending[f] && (5'(f) < {1'b0, i_current_floor})) begin
                w_below_found = 1'b1;
                w_below_floor = 4'(f);
            end
        end
    end

`ifdef SCHED_ENROUTE_EN
    logic       w_er_found;
    logic [3:0] w_er_floor;

    // Candidates exclude the very next floor so the car always has a floor of stopping distance.
    always_comb begin
        w_er_found = 1'b0;
        w_er_floor = '0;
        if (r_dir_up) begin
            for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
                if (r_pending[f] && ({1'b0, i_current_floor} + 5'd1 < 5'(f))
                    && (5'(f) < {1'b0, r_target})) begin
                    w_er_found = 1'b1;
                    w_er_floor = 4'(f);
                end
            end
        end else begin
            for (int f = 0; f < NUM_FLOORS; f++) begin
                if (r_pending[f] && (5'(f) > {1'b0, r_target})
                    && (5'(f) + 5'd1 < {1'b0, i_current_floor})) begin
                    w_er_found = 1'b1;
                    w_er_floor = 4'(f);
                end
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_target_nxt    = r_target;
        w_dir_up_nxt    = r_dir_up;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_clear         = '0;
        w_absorb        = '0;
        case (r_state)
            ST_IDLE: begin
                if ((|r_pending) && i_car_idle) begin
                    if (|(r_pending & w_cur_onehot)) begin
                        w_clear         = w_cur_onehot;
                        w_state_nxt     = ST_DWELL;
                        w_dwell_cnt_nxt = DWELL_LOAD;
                    end else begin
                        w_state_nxt = ST_TRAVEL;
                        if (r_dir_up && w_above_found) begin
                            w_target_nxt = w_above_floor;
                        end else if (r_dir_up) begin
                            w_dir_up_nxt = 1'b0;
                            w_target_nxt = w_below_floor;
                        end else if (w_below_found) begin
                            w_target_nxt = w_below_floor;
                        end else begin
                            w_dir_up_nxt = 1'b1;
                            w_target_nxt = w_above_floor;
                        end
                    end
                end
            end
            ST_TRAVEL: begin
                if (i_car_idle) begin
                    if (i_current_floor == r_target) begin
                        w_clear         = w_tgt_onehot;
                        w_state_nxt     = ST_DWELL;
                        w_dwell_cnt_nxt = DWELL_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
`ifdef SCHED_ENROUTE_EN
                else if (w_er_found) begin
                    w_target_nxt = w_er_floor;
                end
`endif
            end
            ST_DWELL: begin
                w_absorb = w_cur_onehot;
                if (r_dwell_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_dwell_cnt_nxt = r_dwell_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_pending_nxt = (r_pending | (i_call_req & ~w_absorb)) & ~w_clear;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_target    <= '0;
            r_dir_up    <= 1'b1;
            r_dwell_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_target    <= w_target_nxt;
            r_dir_up    <= w_dir_up_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
        end
    end

    // Outside TRAVEL the car's requested floor follows its position; forced to 0 while in reset.
    assign o_target_floor = i_reset ? 4'd0 : ((r_state == ST_TRAVEL) ? r_target : i_current_floor);
    assign o_target_valid = (r_state == ST_TRAVEL);
    assign o_door_open    = (r_state == ST_DWELL);
    assign o_dir_up       = r_dir_up;
    assign o_pending      = r_pending;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: directed scenarios plus random calls with a simple car model,
// all outputs compared each cycle against a behavioural scheduler model.
module tb_elevator_request_scheduler;
    localparam int NF = 10;
    localparam int DW = 8;
    localparam int M_IDLE = 0, M_TRAVEL = 1, M_DWELL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NF-1:0] call;
    logic [3:0]    cur;
    logic          idle;
    logic [3:0]    o_target_floor;
    logic          o_target_valid;
    logic          o_dir_up;
    logic          o_door_open;
    logic [NF-1:0] o_pending;

    always #5 clk = ~clk;

    elevator_request_scheduler #(.NUM_FLOORS(NF), .DWELL_CYCLES(DW)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_call_req     (call),
        .i_current_floor(cur),
        .i_car_idle     (idle),
        .o_target_floor (o_target_floor),
        .o_target_valid (o_target_valid),
        .o_dir_up       (o_dir_up),
        .o_door_open    (o_door_open),
        .o_pending      (o_pending)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model: what the scheduler is doing, in plain integers.
    int m_mode;
    bit m_pend[NF];
    int m_tgt;
    bit m_dir;
    int m_left;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NF-1:0] oh(input int f);
        logic [NF-1:0] v;
        v = '0;
        v[f] = 1'b1;
        return v;
    endfunction

    function automatic bit any_pending();
        for (int f = 0; f < NF; f++) if (m_pend[f]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int nearest_above(input int c);
        for (int f = c + 1; f < NF; f++) if (m_pend[f]) return f;
        return -1;
    endfunction

    function automatic int nearest_below(input int c);
        for (int f = NF - 1; f >= 0; f--) if (f < c && m_pend[f]) return f;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_tgt  = 0;
        m_dir  = 1'b1;
        m_left = 0;
        for (int f = 0; f < NF; f++) m_pend[f] = 1'b0;
    endtask

`ifdef SCHED_ENROUTE_EN
    task automatic enroute(input int c);
        int hit;
        hit = -1;
        if (m_dir) begin
            for (int f = m_tgt - 1; f > c + 1; f--) if (m_pend[f]) hit = f;
        end else begin
            for (int f = m_tgt + 1; f < c - 1 && f < NF; f++) if (m_pend[f]) hit = f;
        end
        if (hit >= 0) m_tgt = hit;
    endtask
`endif

    task automatic model_step();
        int c, clr, a, b;
        bit was_dwell;
        if (rst) begin
            model_reset();
            return;
        end
        c = int'(cur);
        clr = -1;
        was_dwell = (m_mode == M_DWELL);
        case (m_mode)
            M_IDLE: begin
                if (any_pending() && idle) begin
                    if (c < NF && m_pend[c]) begin
                        clr = c;
                        m_mode = M_DWELL;
                        m_left = DW;
                    end else begin
                        a = nearest_above(c);
                        b = nearest_below(c);
                        if (m_dir && a >= 0) m_tgt = a;
                        else if (m_dir) begin m_dir = 1'b0; m_tgt = b; end
                        else if (b >= 0) m_tgt = b;
                        else begin m_dir = 1'b1; m_tgt = a; end
                        m_mode = M_TRAVEL;
                    end
                end
            end
            M_TRAVEL: begin
                if (idle) begin
                    if (c == m_tgt) begin
                        clr = m_tgt;
                        m_mode = M_DWELL;
                        m_left = DW;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
`ifdef SCHED_ENROUTE_EN
                else enroute(c);
`endif
            end
            default: begin
                m_left--;
                if (m_left == 0) m_mode = M_IDLE;
            end
        endcase
        for (int f = 0; f < NF; f++) begin
            if (call[f] && !(was_dwell && f == c)) m_pend[f] = 1'b1;
            if (f == clr) m_pend[f] = 1'b0;
        end
    endtask

    task automatic check_all();
        int ep, etf;
        ep = 0;
        for (int f = 0; f < NF; f++) if (m_pend[f]) ep |= (1 << f);
        etf = rst ? 0 : ((m_mode == M_TRAVEL) ? m_tgt : int'(cur));
        check("target_floor", int'(o_target_floor), etf);
        check("target_valid", int'(o_target_valid), (!rst && m_mode == M_TRAVEL) ? 1 : 0);
        check("dir_up", int'(o_dir_up), int'(m_dir));
        check("door_open", int'(o_door_open), (m_mode == M_DWELL) ? 1 : 0);
        check("pending", int'(o_pending), ep);
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) check_all();
    end

    task automatic tick(input logic [NF-1:0] c_req);
        @(negedge clk);
        call = c_req;
        @(posedge clk);
        model_step();
        #2;
        call = '0;
    endtask

    task automatic wait_dwell_end();
        for (int k = 0; k < 30 && o_door_open; k++) tick('0);
        check("dwell_end", int'(o_door_open), 0);
    endtask

    // Wait for a dispatch, check it, then move the car there and let it dwell.
    task automatic serve(input int exp_floor, input int exp_dir);
        for (int k = 0; k < 20 && !o_target_valid; k++) tick('0);
        check("serve_valid", int'(o_target_valid), 1);
        check("serve_target", int'(o_target_floor), exp_floor);
        check("serve_dir", int'(o_dir_up), exp_dir);
        idle = 1'b0;
        tick('0);
        cur  = 4'(exp_floor);
        idle = 1'b1;
        tick('0);
        check("serve_door", int'(o_door_open), 1);
        wait_dwell_end();
    endtask

    int  n;
    int  car_pos;
    bit  moving;
    int  mcnt;
    int  tf;
    logic [NF-1:0] rc;

    initial begin
        rst = 1'b1; call = '0; cur = 4'd0; idle = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_target", int'(o_target_floor), 0);
        check("rst_valid", int'(o_target_valid), 0);
        check("rst_dir", int'(o_dir_up), 1);
        check("rst_door", int'(o_door_open), 0);
        check("rst_pending", int'(o_pending), 0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Single call from floor 0 to floor 5
        tick(oh(5));
        check("call5_latched", int'(o_pending), 32);
        check("call5_not_yet", int'(o_target_valid), 0);
        tick('0);
        check("call5_target", int'(o_target_floor), 5);
        check("call5_valid", int'(o_target_valid), 1);
        idle = 1'b0;
        repeat (3) tick('0);
        cur = 4'd5; idle = 1'b1;
        tick('0);
        n = 0;
        for (int k = 0; k < 30 && o_door_open; k++) begin
            n++;
            tick('0);
        end
        check("call5_dwell_len", n, 8);
        check("call5_cleared", int'(o_pending[5]), 0);

        // SCAN order from floor 4 going up: 6, 9, then 2
        cur = 4'd4; idle = 1'b0;
        tick(oh(2) | oh(6) | oh(9));
        check("scan_pending", int'(o_pending), 'h244);
        idle = 1'b1;
        serve(6, 1);
        serve(9, 1);
        serve(2, 0);

        // Call at the current floor, repeat absorbed during dwell
        cur = 4'd3;
        tick(oh(3));
        check("cur_no_door_yet", int'(o_door_open), 0);
        tick('0);
        check("cur_door", int'(o_door_open), 1);
        check("cur_no_travel", int'(o_target_valid), 0);
        n = 1;
        tick(oh(3));
        check("cur_absorbed", int'(o_pending[3]), 0);
        if (o_door_open) n++;
        for (int k = 0; k < 30 && o_door_open; k++) begin
            tick('0);
            if (o_door_open) n++;
        end
        check("cur_dwell_len", n, 8);

        // Overshoot: target 5, car stops at 6
        tick(oh(5));
        tick('0);
        check("ovs_target", int'(o_target_floor), 5);
        check("ovs_dir_up", int'(o_dir_up), 1);
        idle = 1'b0;
        tick('0);
        cur = 4'd6; idle = 1'b1;
        tick('0);
        check("ovs_back_idle", int'(o_target_valid), 0);
        check("ovs_kept", int'(o_pending[5]), 1);
        tick('0);
        check("ovs_redispatch", int'(o_target_floor), 5);
        check("ovs_dir_down", int'(o_dir_up), 0);
        idle = 1'b0;
        tick('0);
        cur = 4'd5; idle = 1'b1;
        tick('0);
        wait_dwell_end();

        // Out-of-range car position: nothing counts as above
        tick(oh(8));
        serve(8, 1);
        cur = 4'd12;
        tick(oh(7));
        serve(7, 0);

`ifdef SCHED_ENROUTE_EN
        cur = 4'd0;
        tick(oh(8));
        tick('0);
        check("er_target8", int'(o_target_floor), 8);
        idle = 1'b0; cur = 4'd1;
        tick(oh(2));
        tick('0);
        check("er_no_retarget", int'(o_target_floor), 8);
        tick(oh(4));
        tick('0);
        check("er_retarget4", int'(o_target_floor), 4);
        check("er_keep8", int'(o_pending[8]), 1);
        serve(4, 1);
        serve(8, 1);
        serve(2, 0);
`endif

        // Reset in the middle of a trip
        cur = 4'd2; idle = 1'b1;
        tick(oh(6));
        tick('0);
        check("pre_rst_valid", int'(o_target_valid), 1);
        idle = 1'b0;
        tick(oh(9));
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst_target", int'(o_target_floor), 0);
        check("midrst_valid", int'(o_target_valid), 0);
        check("midrst_dir", int'(o_dir_up), 1);
        check("midrst_door", int'(o_door_open), 0);
        check("midrst_pending", int'(o_pending), 0);
        tick('0);
        @(negedge clk);
        rst = 1'b0; idle = 1'b1;

        // Random calls with a car that moves one floor per 3 cycles and sometimes overshoots
        car_pos = int'(cur); moving = 1'b0; mcnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            tf = int'(o_target_floor);
            if (!moving && o_target_valid && tf != car_pos) begin
                moving = 1'b1;
                mcnt = 0;
            end
            if (moving) begin
                mcnt++;
                if (mcnt == 3) begin
                    mcnt = 0;
                    car_pos += (tf > car_pos) ? 1 : -1;
                    if (car_pos == tf) begin
                        moving = 1'b0;
                        if ($urandom_range(0, 9) == 0)
                            car_pos = (tf + 1 < NF) ? tf + 1 : tf - 1;
                    end
                end
            end
            cur  = 4'(car_pos);
            idle = !moving;
            rc = '0;
            if ($urandom_range(0, 4) == 0) rc[$urandom_range(0, NF - 1)] = 1'b1;
            call = rc;
            @(posedge clk);
            model_step();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
